// File: rtl/counter_pkg.sv
// Shared types and parameter checks for the loadable up/down counter.
package counter_pkg;

   typedef enum logic {
      DOWN = 1'b0,
      UP   = 1'b1
   } dir_e;

   typedef enum logic {
      WRAP = 1'b0,
      SAT  = 1'b1
   } bnd_policy_e;

   // True when max_count fits in a width-bit counter (widths 1..32).
   function automatic bit max_count_ok(input int width, input int unsigned max_count);
      longint unsigned limit;
      if (width < 1 || width > 32) return 1'b0;
      limit = (64'd1 << width) - 64'd1;
      return ({32'd0, max_count} <= limit);
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider: asserts step_out on every PRESCALE-th enabled cycle.
module counter_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic enable,
   output logic step_out
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign step_out = enable && (cnt == LAST);

   // Disabled cycles freeze the phase so a gap in enable delays the step.
   always_ff @(posedge clock) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised loadable up/down counter with modulo bound and wrap/saturate policy.
// Optional macro COUNTER_PRESCALE_EN gates counting through counter_prescaler.
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int          WIDTH     = 4,
   parameter int unsigned MAX_COUNT = (32'd1 << WIDTH) - 32'd1,
   parameter int          PRESCALE  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   input  logic             mode,
   input  logic             enable,
   input  logic             sat_mode,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] data_out,
   output logic             tc,
   output logic             bnd_flag,
   output logic             load_err
);

   if (!max_count_ok(WIDTH, MAX_COUNT)) begin : g_bad_max
      $fatal(1, "updown_counter_mod: MAX_COUNT does not fit in WIDTH bits");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $fatal(1, "updown_counter_mod: PRESCALE must be >= 1");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];

   dir_e        dir;
   bnd_policy_e policy;
   logic        step;
   logic        at_top;
   logic        at_bottom;

   assign dir       = dir_e'(mode);
   assign policy    = bnd_policy_e'(sat_mode);
   assign at_top    = (data_out == MAX_VAL);
   assign at_bottom = (data_out == '0);

`ifdef COUNTER_PRESCALE_EN
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock    (clock),
      .reset    (reset),
      .clr      (load),
      .enable   (enable),
      .step_out (step)
   );
`else
   assign step = enable;
`endif

   // Flag sets are written after the clear so a same-edge set wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_out <= '0;
         tc       <= 1'b0;
         bnd_flag <= 1'b0;
         load_err <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (clr_flags) begin
            bnd_flag <= 1'b0;
            load_err <= 1'b0;
         end
         if (load) begin
            if (data_in > MAX_VAL) begin
               data_out <= MAX_VAL;
               load_err <= 1'b1;
            end else begin
               data_out <= data_in;
            end
         end else if (step) begin
            if (dir == UP) begin
               if (at_top) begin
                  tc       <= 1'b1;
                  bnd_flag <= 1'b1;
                  if (policy == WRAP) data_out <= '0;
               end else begin
                  data_out <= data_out + WIDTH'(1);
               end
            end else begin
               if (at_bottom) begin
                  tc       <= 1'b1;
                  bnd_flag <= 1'b1;
                  if (policy == WRAP) data_out <= MAX_VAL;
               end else begin
                  data_out <= data_out - WIDTH'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: a full-range (15) and a mod-12 (11) instance
// checked every cycle against an arithmetic model, plus directed literal checks.
module tb_updown_counter_mod;

   localparam int PRESCALE = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] data_in;
   logic       load, mode, enable, sat_mode, clr_flags;

   logic [3:0] d0_out, d1_out;
   logic       d0_tc, d1_tc, d0_bnd, d1_bnd, d0_lerr, d1_lerr;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   int mx[2] = '{15, 11};
   int m_cnt[2], m_pre[2];
   bit m_tc[2], m_bnd[2], m_lerr[2];
   bit ev, q;

   always #5 clock = ~clock;

   updown_counter_mod #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(PRESCALE)) dut (
      .clock(clock), .reset(reset), .data_in(data_in), .load(load), .mode(mode),
      .enable(enable), .sat_mode(sat_mode), .clr_flags(clr_flags),
      .data_out(d0_out), .tc(d0_tc), .bnd_flag(d0_bnd), .load_err(d0_lerr)
   );

   updown_counter_mod #(.WIDTH(4), .MAX_COUNT(11), .PRESCALE(PRESCALE)) dut11 (
      .clock(clock), .reset(reset), .data_in(data_in), .load(load), .mode(mode),
      .enable(enable), .sat_mode(sat_mode), .clr_flags(clr_flags),
      .data_out(d1_out), .tc(d1_tc), .bnd_flag(d1_bnd), .load_err(d1_lerr)
   );

   // Reference model: modulo arithmetic on plain ints.
   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_bnd[k] = 0; m_lerr[k] = 0;
         end else begin
            m_tc[k] = 0;
            if (clr_flags) begin m_bnd[k] = 0; m_lerr[k] = 0; end
            if (load) begin
               m_pre[k] = 0;
               if (int'(data_in) > mx[k]) begin m_cnt[k] = mx[k]; m_lerr[k] = 1; end
               else m_cnt[k] = int'(data_in);
            end else if (enable) begin
`ifdef COUNTER_PRESCALE_EN
               q = (m_pre[k] == PRESCALE - 1);
               m_pre[k] = q ? 0 : m_pre[k] + 1;
`else
               q = 1;
`endif
               if (q) begin
                  ev = mode ? (m_cnt[k] == mx[k]) : (m_cnt[k] == 0);
                  if (!(ev && sat_mode))
                     m_cnt[k] = mode ? (m_cnt[k] + 1) % (mx[k] + 1)
                                     : (m_cnt[k] + mx[k]) % (mx[k] + 1);
                  if (ev) begin m_tc[k] = 1; m_bnd[k] = 1; end
               end
            end
         end
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_on) begin
         cmp("i15.data_out", 32'(d0_out), 32'(m_cnt[0]));
         cmp("i15.tc",       32'(d0_tc),  32'(m_tc[0]));
         cmp("i15.bnd_flag", 32'(d0_bnd), 32'(m_bnd[0]));
         cmp("i15.load_err", 32'(d0_lerr), 32'(m_lerr[0]));
         cmp("i11.data_out", 32'(d1_out), 32'(m_cnt[1]));
         cmp("i11.tc",       32'(d1_tc),  32'(m_tc[1]));
         cmp("i11.bnd_flag", 32'(d1_bnd), 32'(m_bnd[1]));
         cmp("i11.load_err", 32'(d1_lerr), 32'(m_lerr[1]));
      end
   end

   task automatic drv(input bit rst, input bit ld, input logic [3:0] din,
                      input bit md, input bit en, input bit sat, input bit clr);
      @(negedge clock);
      reset = rst; load = ld; data_in = din; mode = md;
      enable = en; sat_mode = sat; clr_flags = clr;
      @(posedge clock);
      #1;
   endtask

`ifdef COUNTER_PRESCALE_EN
   task automatic directed();
      drv(1, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 0, 1, 1, 0, 0);
         cmp("pre.no_step", 32'(d0_out), 32'd0);
      end
      drv(0, 0, 0, 1, 1, 0, 0);
      cmp("pre.step4", 32'(d0_out), 32'd1);
      drv(0, 0, 0, 1, 1, 0, 0);
      drv(0, 0, 0, 1, 1, 0, 0);
      drv(0, 0, 0, 1, 0, 0, 0);
      drv(0, 0, 0, 1, 0, 0, 0);
      drv(0, 0, 0, 1, 1, 0, 0);
      cmp("pre.gap_hold", 32'(d0_out), 32'd1);
      drv(0, 0, 0, 1, 1, 0, 0);
      cmp("pre.gap_step", 32'(d0_out), 32'd2);
   endtask
`else
   task automatic directed();
      drv(0, 1, 4'hA, 1, 0, 0, 0);
      cmp("load_a.out", 32'(d0_out), 32'd10);
      cmp("load_a.tc",  32'(d0_tc),  32'd0);
      cmp("load_a.bnd", 32'(d0_bnd), 32'd0);
      // Up/wrap from 14; the mod-12 instance clamps 14 to 11.
      drv(0, 1, 4'd14, 1, 0, 0, 0);
      cmp("clamp.out",  32'(d1_out),  32'd11);
      cmp("clamp.lerr", 32'(d1_lerr), 32'd1);
      drv(0, 0, 0, 1, 1, 0, 0);
      cmp("wrap.15",    32'(d0_out), 32'd15);
      cmp("wrap.tc_lo", 32'(d0_tc),  32'd0);
      cmp("wrap11.0",   32'(d1_out), 32'd0);
      cmp("wrap11.tc",  32'(d1_tc),  32'd1);
      drv(0, 0, 0, 1, 1, 0, 0);
      cmp("wrap.0",     32'(d0_out), 32'd0);
      cmp("wrap.tc",    32'(d0_tc),  32'd1);
      cmp("wrap.bnd",   32'(d0_bnd), 32'd1);
      drv(0, 0, 0, 1, 1, 0, 0);
      cmp("wrap.1",     32'(d0_out), 32'd1);
      cmp("wrap.tc_end", 32'(d0_tc), 32'd0);
      cmp("wrap.bnd_sticky", 32'(d0_bnd), 32'd1);
      drv(0, 0, 0, 1, 0, 0, 1);
      cmp("clr.bnd",    32'(d0_bnd), 32'd0);
      // Down/saturate from 1.
      drv(0, 1, 4'd1, 0, 0, 1, 0);
      drv(0, 0, 0, 0, 1, 1, 0);
      cmp("sat.0",      32'(d0_out), 32'd0);
      cmp("sat.tc0",    32'(d0_tc),  32'd0);
      for (int i = 0; i < 2; i++) begin
         drv(0, 0, 0, 0, 1, 1, 0);
         cmp("sat.hold",  32'(d0_out), 32'd0);
         cmp("sat.tc_hi", 32'(d0_tc),  32'd1);
      end
      // Load 15 while clearing; over-range set on the mod-12 instance beats the clear.
      drv(0, 1, 4'd15, 1, 0, 0, 1);
      cmp("ldclr.bnd",   32'(d0_bnd),  32'd0);
      cmp("ldclr.lerr11", 32'(d1_lerr), 32'd1);
      drv(0, 1, 4'd3, 1, 1, 0, 0);
      cmp("ld_en.out",  32'(d0_out), 32'd3);
      cmp("ld_en.tc",   32'(d0_tc),  32'd0);
      cmp("ld_en.bnd",  32'(d0_bnd), 32'd0);
      drv(0, 0, 0, 1, 1, 0, 0);
      drv(1, 0, 0, 1, 1, 0, 0);
      cmp("rst.out",    32'(d0_out), 32'd0);
      cmp("rst.lerr11", 32'(d1_lerr), 32'd0);
   endtask
`endif

   initial begin
      reset = 1'b1; load = 0; data_in = 0; mode = 1; enable = 0; sat_mode = 0; clr_flags = 0;
      @(posedge clock);
      #1;
      chk_on = 1'b1;
      drv(1, 0, 0, 1, 0, 0, 0);
      cmp("reset.out", 32'(d0_out), 32'd0);
      cmp("reset.tc",  32'(d0_tc),  32'd0);
      directed();
      for (int i = 0; i < 600; i++) begin
         drv($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), $urandom_range(0, 99) < 75,
             1'($urandom_range(0, 1)), $urandom_range(0, 99) < 8);
      end
      @(negedge clock);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
